// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: steps a 4-bit PWM duty value one LSB every STEP_CYCLES
// clocks toward an accepted target, with an emergency stop that forces duty 0.
// Optional feature macro: PWM_SEQ_BREATHE_EN adds the breathe_en input and a
// continuous 0..15..0 triangle sweep state.
module pwm_duty_sequencer #(
  parameter int STEP_CYCLES = 80000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] tgt_duty,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic       stop,
`ifdef PWM_SEQ_BREATHE_EN
  input  logic       breathe_en,
`endif
  output logic [3:0] duty,
  output logic       busy,
  output logic       done
);

  localparam int             CW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP    = 2'd1
`ifdef PWM_SEQ_BREATHE_EN
    ,BREATHE = 2'd2
`endif
  } state_t;

  state_t        state, state_n;
  logic [3:0]    duty_n, target, target_n, step;
  logic [CW-1:0] cnt, cnt_n;
  logic          done_n, wrap;
`ifdef PWM_SEQ_BREATHE_EN
  logic          dir, dir_n;   // 1 = sweeping up
`endif

  assign wrap      = (cnt == LAST);
  assign tgt_ready = (state == IDLE) && !stop;
  assign busy      = (state != IDLE);
  // One LSB toward the target; the ramp only ever moves toward an in-range
  // target, so duty cannot leave 0..15.
  assign step      = (duty > target) ? duty - 4'd1 : duty + 4'd1;

  // Register all sequencer state; reset wins asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      duty   <= 4'd0;
      cnt    <= '0;
      target <= 4'd0;
      done   <= 1'b0;
`ifdef PWM_SEQ_BREATHE_EN
      dir    <= 1'b1;
`endif
    end else begin
      state  <= state_n;
      duty   <= duty_n;
      cnt    <= cnt_n;
      target <= target_n;
      done   <= done_n;
`ifdef PWM_SEQ_BREATHE_EN
      dir    <= dir_n;
`endif
    end
  end

  // Next-state logic: stop overrides everything, then per-state behaviour.
  always_comb begin
    state_n  = state;
    duty_n   = duty;
    cnt_n    = cnt;
    target_n = target;
    done_n   = 1'b0;
`ifdef PWM_SEQ_BREATHE_EN
    dir_n    = dir;
`endif
    if (stop) begin
      state_n  = IDLE;
      duty_n   = 4'd0;
      cnt_n    = '0;
      target_n = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (tgt_valid) begin
            target_n = tgt_duty;
            cnt_n    = '0;
            if (tgt_duty == duty) done_n  = 1'b1;
            else                  state_n = RAMP;
          end
`ifdef PWM_SEQ_BREATHE_EN
          else if (breathe_en) begin
            state_n = BREATHE;
            cnt_n   = '0;
            dir_n   = (duty != 4'd15);
          end
`endif
        end
        RAMP: begin
          cnt_n = wrap ? '0 : cnt + CW'(1);
          if (wrap) begin
            duty_n = step;
            if (step == target) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
`ifdef PWM_SEQ_BREATHE_EN
        BREATHE: begin
          if (!breathe_en) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = wrap ? '0 : cnt + CW'(1);
            if (wrap) begin
              // Reverse on the step that lands on an end point.
              if (dir) begin
                duty_n = duty + 4'd1;
                if (duty == 4'd14) dir_n = 1'b0;
              end else begin
                duty_n = duty - 4'd1;
                if (duty == 4'd1) dir_n = 1'b1;
              end
            end
          end
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer with STEP_CYCLES = 4.
module tb_pwm_duty_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] tgt_duty;
  logic       tgt_valid;
  logic       tgt_ready;
  logic       stop;
`ifdef PWM_SEQ_BREATHE_EN
  logic       breathe_en = 1'b0;
`endif
  logic [3:0] duty;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  pwm_duty_sequencer #(.STEP_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_duty  (tgt_duty),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .stop      (stop),
`ifdef PWM_SEQ_BREATHE_EN
    .breathe_en(breathe_en),
`endif
    .duty      (duty),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ramp to value d and wait (bounded) for the done pulse.
  task automatic go_to(input logic [3:0] d);
    bit ok = 0;
    tgt_duty  = d;
    tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin ok = 1; break; end
      tick();
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL go_to_timeout target=%0d duty=%0d", d, duty); end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; stop = 1'b0; tgt_valid = 1'b0; tgt_duty = 4'd0;
    repeat (3) tick();
    checks++;
    if ({duty, busy, done} !== 6'b0) begin
      failures++; $display("FAIL reset_state duty=%0d busy=%0b done=%0b want 0/0/0", duty, busy, done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (tgt_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b want=1", tgt_ready); end
  endtask

  task automatic test_ramp_up();
    tgt_duty = 4'd3; tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      checks++;
      if (duty !== 4'((k > 12 ? 12 : k) / 4) || done !== (k == 12) || busy !== (k < 12)) begin
        failures++;
        $display("FAIL ramp_up k=%0d duty=%0d done=%0b busy=%0b want %0d/%0b/%0b",
                 k, duty, done, busy, (k > 12 ? 12 : k) / 4, k == 12, k < 12);
      end
    end
  endtask

  task automatic test_ramp_down();
    go_to(4'd15);
    tgt_duty = 4'd12; tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      tgt_valid = 1'b0;
      checks++;
      if (duty !== 4'(15 - k / 4) || done !== (k == 12)) begin
        failures++;
        $display("FAIL ramp_down k=%0d duty=%0d done=%0b want %0d/%0b", k, duty, done, 15 - k / 4, k == 12);
      end
      if (k == 3) begin
        checks++;
        if (tgt_ready !== 1'b0) begin failures++; $display("FAIL ramp_ready got=%0b want=0", tgt_ready); end
      end
      // Stray requests during the ramp must be ignored.
      if (k == 2 || k == 7) begin tgt_duty = 4'd5; tgt_valid = 1'b1; end
    end
    tick();
    checks++;
    if (duty !== 4'd12 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL ramp_down_end duty=%0d busy=%0b done=%0b want 12/0/0", duty, busy, done);
    end
  endtask

  task automatic test_stop();
    go_to(4'd2);
    tgt_duty = 4'd10; tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    checks++;
    if (duty !== 4'd5) begin failures++; $display("FAIL stop_pre duty=%0d want=5", duty); end
    stop = 1'b1;
    tick();
    checks++;
    if (duty !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || tgt_ready !== 1'b0) begin
      failures++;
      $display("FAIL stop_force duty=%0d busy=%0b done=%0b ready=%0b want 0/0/0/0", duty, busy, done, tgt_ready);
    end
    tick();
    stop = 1'b0;
    #1;
    checks++;
    if (tgt_ready !== 1'b1) begin failures++; $display("FAIL stop_release_ready got=%0b want=1", tgt_ready); end
    tick();
    checks++;
    if (duty !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL stop_after duty=%0d done=%0b busy=%0b want 0/0/0", duty, done, busy);
    end
  endtask

  task automatic test_same_target();
    go_to(4'd7);
    tgt_duty = 4'd7; tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || duty !== 4'd7) begin
      failures++; $display("FAIL same_accept done=%0b busy=%0b duty=%0d want 1/0/7", done, busy, duty);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || duty !== 4'd7) begin
      failures++; $display("FAIL same_after done=%0b busy=%0b duty=%0d want 0/0/7", done, busy, duty);
    end
    stop = 1'b1; tgt_duty = 4'd3; tgt_valid = 1'b1;
    tick();
    stop = 1'b0; tgt_valid = 1'b0;
    checks++;
    if (duty !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL stop_valid duty=%0d busy=%0b done=%0b want 0/0/0", duty, busy, done);
    end
    repeat (5) tick();
    checks++;
    if (duty !== 4'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL stop_valid_noaccept duty=%0d busy=%0b want 0/0", duty, busy);
    end
  endtask

  task automatic test_reset_mid_ramp();
    tgt_duty = 4'd9; tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    repeat (6) tick();
    checks++;
    if (duty !== 4'd1 || busy !== 1'b1) begin
      failures++; $display("FAIL mid_pre duty=%0d busy=%0b want 1/1", duty, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (duty !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mid_async duty=%0d busy=%0b done=%0b want 0/0/0", duty, busy, done);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (tgt_ready !== 1'b1 || duty !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_release ready=%0b duty=%0d busy=%0b done=%0b want 1/0/0/0", tgt_ready, duty, busy, done);
    end
  endtask

`ifdef PWM_SEQ_BREATHE_EN
  task automatic test_breathe();
    int exp_d;
    breathe_en = 1'b1;
    tick();
    for (int k = 1; k <= 126; k++) begin
      tick();
      exp_d = (k / 4) % 30;
      if (exp_d > 15) exp_d = 30 - exp_d;
      checks++;
      if (duty !== 4'(exp_d) || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL breathe k=%0d duty=%0d busy=%0b done=%0b want %0d/1/0", k, duty, busy, done, exp_d);
      end
    end
    breathe_en = 1'b0;
    tick();
    checks++;
    if (duty !== 4'd1 || busy !== 1'b0 || tgt_ready !== 1'b1) begin
      failures++; $display("FAIL breathe_exit duty=%0d busy=%0b ready=%0b want 1/0/1", duty, busy, tgt_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_stop();
    test_same_target();
    test_reset_mid_ramp();
`ifdef PWM_SEQ_BREATHE_EN
    test_breathe();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
